// File: rtl/bsg_manycore_subpod_link_reset_seq_pkg.sv
// Shared types and sizing helpers for the subpod link/core reset sequencer.
package bsg_manycore_subpod_link_reset_seq_pkg;

  // WAIT_ALIVE and ERROR keep their codes even when the watchdog is compiled out
  typedef enum logic [3:0] {
    s_idle       = 4'd0,
    s_assert     = 4'd1,
    s_token      = 4'd2,
    s_settle     = 4'd3,
    s_up         = 4'd4,
    s_down       = 4'd5,
    s_ds         = 4'd6,
    s_done       = 4'd7,
    s_wait_alive = 4'd8,
    s_error      = 4'd9
  } state_e;

  function automatic int safe_clog2(input int x);
    int r;
    r = 0;
    while ((1 << r) < x) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Counter width wide enough to hold the largest dwell value
  function automatic int ctr_width(input int hold, input int tok, input int core, input int timeout);
    return safe_clog2(max4(hold, tok, core, timeout) + 1);
  endfunction

endpackage

// File: rtl/bsg_manycore_reset_seq_timer.sv
// Loadable down-counter shared by every timed state of the reset sequencer.
module bsg_manycore_reset_seq_timer
  import bsg_manycore_subpod_link_reset_seq_pkg::*;
#(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  output logic               zero_o
);

  logic [width_p-1:0] count_r;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      count_r <= '0;
    else if (load_i)
      count_r <= load_val_i;
    else if (count_r != '0)
      count_r <= count_r - 1'b1;
  end

  assign zero_o = (count_r == '0);

endmodule

// File: rtl/bsg_manycore_subpod_link_reset_seq.sv
// Sequences bsg_link_sdr token/uplink/downlink/downstream resets and the core reset.
// Optional link-alive watchdog with retries: BSG_MANYCORE_SUBPOD_LINK_WATCHDOG_EN.
module bsg_manycore_subpod_link_reset_seq
  import bsg_manycore_subpod_link_reset_seq_pkg::*;
#(
  parameter int hold_cycles_p        = 16,
  parameter int token_pulse_cycles_p = 4,
  parameter int core_delay_cycles_p  = 32,
  parameter int timeout_cycles_p     = 1024,
  parameter int max_retries_p        = 3
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       disable_i,
  input  logic       link_alive_i,
  output logic       token_reset_o,
  output logic       uplink_reset_o,
  output logic       downlink_reset_o,
  output logic       downstream_reset_o,
  output logic       core_reset_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [3:0] state_o
);

  localparam int cw_lp = ctr_width(hold_cycles_p, token_pulse_cycles_p,
                                   core_delay_cycles_p, timeout_cycles_p);

  // Timer holds N-1 on entry so the state dwells exactly N cycles
  localparam logic [cw_lp-1:0] hold_ld_lp = cw_lp'(hold_cycles_p - 1);
  localparam logic [cw_lp-1:0] tok_ld_lp  = cw_lp'(token_pulse_cycles_p - 1);
  localparam logic [cw_lp-1:0] core_ld_lp = cw_lp'(core_delay_cycles_p - 1);

  state_e             state_r, state_n;
  logic               timer_load;
  logic [cw_lp-1:0]   timer_load_val;
  logic               timer_zero;

  bsg_manycore_reset_seq_timer #(.width_p(cw_lp)) timer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (timer_load),
    .load_val_i (timer_load_val),
    .zero_o     (timer_zero)
  );

`ifdef BSG_MANYCORE_SUBPOD_LINK_WATCHDOG_EN
  localparam int rw_lp = safe_clog2(max_retries_p + 1);
  localparam logic [cw_lp-1:0] timeout_ld_lp = cw_lp'(timeout_cycles_p - 1);
  localparam logic [rw_lp-1:0] retry_max_lp  = rw_lp'(max_retries_p);

  logic [rw_lp-1:0] retry_cnt_r;
  logic             retry_clr, retry_inc;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      retry_cnt_r <= '0;
    else if (retry_clr)
      retry_cnt_r <= '0;
    else if (retry_inc)
      retry_cnt_r <= retry_cnt_r + 1'b1;
  end
`else
  logic unused_watchdog_cfg;
  assign unused_watchdog_cfg = link_alive_i ^ (max_retries_p != 0);
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i)
      state_r <= s_idle;
    else
      state_r <= state_n;
  end

  always_comb begin
    state_n        = state_r;
    timer_load     = 1'b0;
    timer_load_val = '0;
`ifdef BSG_MANYCORE_SUBPOD_LINK_WATCHDOG_EN
    retry_clr      = 1'b0;
    retry_inc      = 1'b0;
`endif
    case (state_r)
      s_idle, s_done: begin
        if (start_i) begin
          state_n = s_assert; timer_load = 1'b1; timer_load_val = hold_ld_lp;
        end
      end
      s_assert: if (timer_zero) begin
        state_n = s_token; timer_load = 1'b1; timer_load_val = tok_ld_lp;
      end
      s_token: if (timer_zero) begin
        state_n = s_settle; timer_load = 1'b1; timer_load_val = hold_ld_lp;
      end
      s_settle: if (timer_zero) begin
        state_n = s_up; timer_load = 1'b1; timer_load_val = hold_ld_lp;
      end
      s_up: if (timer_zero) begin
        state_n = s_down; timer_load = 1'b1; timer_load_val = hold_ld_lp;
      end
      s_down: if (timer_zero) begin
        state_n = s_ds; timer_load = 1'b1; timer_load_val = core_ld_lp;
      end
`ifdef BSG_MANYCORE_SUBPOD_LINK_WATCHDOG_EN
      s_ds: if (timer_zero) begin
        state_n = s_wait_alive; timer_load = 1'b1; timer_load_val = timeout_ld_lp;
      end
      s_wait_alive: begin
        if (link_alive_i) begin
          state_n = s_done; retry_clr = 1'b1;
        end else if (timer_zero) begin
          if (retry_cnt_r == retry_max_lp) begin
            state_n = s_error;
          end else begin
            state_n = s_assert; timer_load = 1'b1; timer_load_val = hold_ld_lp;
            retry_inc = 1'b1;
          end
        end
      end
      s_error: if (start_i) begin
        state_n = s_assert; timer_load = 1'b1; timer_load_val = hold_ld_lp;
        retry_clr = 1'b1;
      end
`else
      s_ds: if (timer_zero) state_n = s_done;
`endif
      default: state_n = s_idle;
    endcase
    // disable overrides everything, including a same-cycle start
    if (disable_i) begin
      state_n    = s_idle;
      timer_load = 1'b0;
`ifdef BSG_MANYCORE_SUBPOD_LINK_WATCHDOG_EN
      retry_clr  = 1'b1;
      retry_inc  = 1'b0;
`endif
    end
  end

  always_comb begin
    token_reset_o      = 1'b0;
    uplink_reset_o     = 1'b1;
    downlink_reset_o   = 1'b1;
    downstream_reset_o = 1'b1;
    core_reset_o       = 1'b1;
    busy_o             = 1'b0;
    done_o             = 1'b0;
    err_o              = 1'b0;
    case (state_r)
      s_assert, s_settle: busy_o = 1'b1;
      s_token: begin
        token_reset_o = 1'b1; busy_o = 1'b1;
      end
      s_up: begin
        uplink_reset_o = 1'b0; busy_o = 1'b1;
      end
      s_down: begin
        uplink_reset_o = 1'b0; downlink_reset_o = 1'b0; busy_o = 1'b1;
      end
`ifdef BSG_MANYCORE_SUBPOD_LINK_WATCHDOG_EN
      s_ds, s_wait_alive: begin
`else
      s_ds: begin
`endif
        uplink_reset_o = 1'b0; downlink_reset_o = 1'b0;
        downstream_reset_o = 1'b0; busy_o = 1'b1;
      end
      s_done: begin
        uplink_reset_o = 1'b0; downlink_reset_o = 1'b0;
        downstream_reset_o = 1'b0; core_reset_o = 1'b0; done_o = 1'b1;
      end
`ifdef BSG_MANYCORE_SUBPOD_LINK_WATCHDOG_EN
      s_error: err_o = 1'b1;
`endif
      default: ;
    endcase
  end

  assign state_o = state_r;

endmodule

// File: doc/bsg_manycore_subpod_link_reset_seq.md
Name: bsg_manycore_subpod_link_reset_seq

Overview:
- On-chip sequencer for the subpod's SDR link and core resets.
- Replaces hand-timed tag writes. One start pulse drives the full bsg_link_sdr bring-up order: assert all resets, pulse the token reset, release uplink, then downlink, then downstream, then release core reset.
- Sits beside the fwd/rev bsg_link_sdr pairs in core_clk. Its outputs feed every link's reset pins and the hetero socket's reset.

Parameters:
- hold_cycles_p, 16: cycles spent in each ASSERT/SETTLE/UP/DOWN step; must be >= 1.
- token_pulse_cycles_p, 4: width of the token_reset_o pulse in cycles; must be >= 1.
- core_delay_cycles_p, 32: cycles between downstream release and core release; must be >= 1.
- timeout_cycles_p, 1024: link-alive watchdog window (optional feature only).
- max_retries_p, 3: sequence retries before error (optional feature only).

Ports:
- clk_i  in  1  core clock.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  pulse; begins or restarts the sequence.
- disable_i  in  1  level; forces all resets asserted (mirrors sdr_disable).
- link_alive_i  in  1  any link core_v_o seen (used only with the optional feature).
- token_reset_o  out  1  to async_token_reset_i of all links.
- uplink_reset_o  out  1  to core_uplink_reset_i.
- downlink_reset_o  out  1  to async_downlink_reset_i.
- downstream_reset_o  out  1  to core_downstream_reset_i.
- core_reset_o  out  1  socket reset.
- busy_o  out  1  sequence in progress.
- done_o  out  1  link up and core released.
- err_o  out  1  retries exhausted (tied 0 without the optional feature).
- state_o  out  4  current state encoding, for debug.

Behaviour:
- All outputs decode from the registered state, so there are no combinational input-to-output paths.
- Reset values: all four link resets and core_reset_o = 1; token_reset_o = 0; busy_o = 0; done_o = 0; err_o = 0; state = IDLE.
- Each timed state loads a down-counter on entry and exits on the cycle the count reaches 0. Dwell time is exactly the parameter value.
- States and outputs (resets listed as uplink/downlink/downstream/core; tok = token_reset_o):
  - IDLE: 1/1/1/1, tok 0. Exits to ASSERT on start_i & ~disable_i.
  - ASSERT: 1/1/1/1, tok 0, busy. Lasts hold_cycles_p, then TOKEN.
  - TOKEN: tok 1, all resets still 1. Lasts token_pulse_cycles_p, then SETTLE.
  - SETTLE: tok 0, all resets 1. Lasts hold_cycles_p, then UP.
  - UP: uplink = 0. Lasts hold_cycles_p, then DOWN.
  - DOWN: downlink = 0 as well. Lasts hold_cycles_p, then DS.
  - DS: downstream = 0 as well. Lasts core_delay_cycles_p, then DONE.
  - DONE: core = 0, done_o = 1, busy_o = 0. Holds until start_i or disable_i.
- Latency: start_i sampled high at cycle 0 means ASSERT at cycle 1. With defaults, done_o first goes high at cycle 101 (1 + 16 + 4 + 16 + 16 + 16 + 32).
- start_i while busy_o is high: ignored.
- start_i in DONE: go to ASSERT; all resets reassert on the next cycle.
- disable_i high in any state: next state is IDLE. Start is blocked while disable_i is high.
- reset_i mid-sequence: IDLE on the next edge, counter cleared.
- disable_i and start_i high in the same cycle: disable_i wins.
- Reset outputs only ever release in the order uplink, downlink, downstream, core. They all re-assert together.

Optional Feature:
- Macro BSG_MANYCORE_SUBPOD_LINK_WATCHDOG_EN.
- Defined:
  - DS exits to WAIT_ALIVE instead of DONE. WAIT_ALIVE has the same outputs as DS and is busy.
  - link_alive_i high goes to DONE.
  - After timeout_cycles_p without link_alive_i: retry count increments and the FSM returns to ASSERT.
  - When the retry count equals max_retries_p, go to ERROR: all resets 1, err_o = 1, busy_o = 0.
  - ERROR exits only on start_i (clears the retry count, goes to ASSERT) or reset_i.
  - The retry count also clears on reaching DONE.
- Undefined: there is no WAIT_ALIVE or ERROR state, link_alive_i is ignored, and err_o = 0.

Decomposition:
- Package bsg_manycore_subpod_link_reset_seq_pkg holds:
  - the state enum typedef (4 bits, including the WAIT_ALIVE and ERROR encodings, always reserved);
  - the counter-width helper constant: BSG_SAFE_CLOG2 of the maximum of the timed parameters + 1.
- Sub-module bsg_manycore_reset_seq_timer: a loadable down-counter with load_i, load_val_i and zero_o. It is shared by all timed states and the watchdog.

Test Plan:
- Defaults, start_i pulse at cycle 0:
  - uplink falls at cycle 37, downlink at 53, downstream at 69;
  - core_reset_o falls and done_o rises at cycle 101;
  - token_reset_o is high exactly for cycles 17–20.
- start_i pulsed at cycle 40 during the sequence: no effect, done_o still rises at cycle 101. Then start_i in DONE: all resets = 1 on the next cycle, and done_o rises again 101 cycles later.
- disable_i raised at cycle 60 (DOWN): IDLE at 61, all resets = 1. start_i held high with disable_i: stays in IDLE.
- reset_i asserted for 1 cycle during TOKEN: token_reset_o = 0 and state_o = IDLE on the next cycle.
- Watchdog on, timeout_cycles_p = 8, max_retries_p = 2, link_alive_i held 0: two full retries, then err_o = 1. start_i then restarts with the retry count at 0.
- Watchdog on, link_alive_i pulsed 3 cycles into WAIT_ALIVE: DONE on the next cycle, err_o stays 0.
